// File: rtl/reg_sched_pkg.sv
// Shared types and default sizing for the register-bus transfer scheduler.
package reg_sched_pkg;

   // Default number of requesters sharing the internal data bus.
   localparam int NREQ_DEF  = 4;
   // Default number of latches attached to the bus.
   localparam int NLAT_DEF  = 8;
   // Width of a latch index for the default latch count.
   localparam int LAT_IDX_W = $clog2(NLAT_DEF);
   // Width of a requester index for the default requester count.
   localparam int REQ_IDX_W = $clog2(NREQ_DEF);

   // Transfer sequencer states: each transfer walks DRIVE -> WRITE -> TURN.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_WRITE = 2'd2,
      ST_TURN  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/reg_bus_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// returning a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic          found_s;
   logic [IW-1:0] cand_s;

   // Scan requesters from ptr upward (modulo N) and keep the first one asserted.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found_s = 1'b0;
      cand_s  = '0;
      for (int k = 0; k < N; k++) begin
         cand_s = IW'((int'(ptr) + k) % N);
         if (!found_s && req[cand_s]) begin
            found_s     = 1'b1;
            gnt[cand_s] = 1'b1;
            idx         = cand_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/reg_bus_sched.sv
// Register-bus transfer scheduler: arbitrates requesters round-robin and
// sequences one latch-to-latch copy per 3 cycles (drive, write, turnaround).
module reg_bus_sched
   import reg_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int NLAT = NLAT_DEF
) (
   input  logic                                  clk,
   input  logic                                  nreset,
   input  logic [NREQ-1:0]                       req,
   input  logic [NREQ-1:0][$clog2(NLAT)-1:0]     src,
   input  logic [NREQ-1:0][$clog2(NLAT)-1:0]     dst,
   input  logic                                  ext_busy,
   output logic [NLAT-1:0]                       oe,
   output logic [NLAT-1:0]                       we,
   output logic [NREQ-1:0]                       gnt,
   output logic [NREQ-1:0]                       done,
   output logic                                  err
);

   localparam int              LW      = $clog2(NLAT);
   localparam int              RW      = $clog2(NREQ);
   localparam logic [NLAT-1:0] LAT_ONE = {{(NLAT-1){1'b0}}, 1'b1};
   localparam logic [NREQ-1:0] REQ_ONE = {{(NREQ-1){1'b0}}, 1'b1};

   sched_state_e    state_r, state_nx_s;
   logic [RW-1:0]   win_r, win_nx_s;
   logic [RW-1:0]   ptr_r, ptr_nx_s;
   logic [LW-1:0]   src_r, src_nx_s;
   logic [LW-1:0]   dst_r, dst_nx_s;

   logic [NLAT-1:0] oe_nx_s, we_nx_s;
   logic [NREQ-1:0] gnt_nx_s, done_nx_s;
   logic            err_nx_s;

   logic [NREQ-1:0] arb_req_s, arb_gnt_s;
   logic [RW-1:0]   arb_idx_s;
   logic            arb_valid_s;
   logic            start_s;

   // Only IDLE and TURN may launch a transfer; TURN hides the finishing requester.
   always_comb begin
      arb_req_s = '0;
      case (state_r)
         ST_IDLE: arb_req_s = req;
         ST_TURN: arb_req_s = req & ~(REQ_ONE << win_r);
         default: arb_req_s = '0;
      endcase
   end

   assign start_s = arb_valid_s & ~ext_busy;

   rr_arbiter #(
      .N  (NREQ),
      .IW (RW)
   ) u_arb (
      .req   (arb_req_s),
      .ptr   (ptr_r),
      .gnt   (arb_gnt_s),
      .idx   (arb_idx_s),
      .valid (arb_valid_s)
   );

   // Next-state decode; strobes are computed for the state being entered so they register cleanly.
   always_comb begin
      state_nx_s = state_r;
      win_nx_s   = win_r;
      ptr_nx_s   = ptr_r;
      src_nx_s   = src_r;
      dst_nx_s   = dst_r;
      oe_nx_s    = '0;
      we_nx_s    = '0;
      gnt_nx_s   = '0;
      done_nx_s  = '0;
      err_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_TURN: begin
            if (start_s) begin
               state_nx_s = ST_DRIVE;
               win_nx_s   = arb_idx_s;
               src_nx_s   = src[arb_idx_s];
               dst_nx_s   = dst[arb_idx_s];
               if (arb_idx_s == RW'(NREQ - 1)) begin
                  ptr_nx_s = '0;
               end else begin
                  ptr_nx_s = arb_idx_s + RW'(1);
               end
               oe_nx_s    = LAT_ONE << src[arb_idx_s];
               gnt_nx_s   = arb_gnt_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            state_nx_s = ST_WRITE;
            oe_nx_s    = LAT_ONE << src_r;
            if (src_r != dst_r) begin
               we_nx_s = LAT_ONE << dst_r;
            end else begin
               we_nx_s = '0;
            end
         end
         ST_WRITE: begin
            state_nx_s = ST_TURN;
            done_nx_s  = REQ_ONE << win_r;
            err_nx_s   = (src_r == dst_r);
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, captured transfer context and registered strobes; reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r <= ST_IDLE;
         win_r   <= '0;
         ptr_r   <= '0;
         src_r   <= '0;
         dst_r   <= '0;
         oe      <= '0;
         we      <= '0;
         gnt     <= '0;
         done    <= '0;
         err     <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         win_r   <= win_nx_s;
         ptr_r   <= ptr_nx_s;
         src_r   <= src_nx_s;
         dst_r   <= dst_nx_s;
         oe      <= oe_nx_s;
         we      <= we_nx_s;
         gnt     <= gnt_nx_s;
         done    <= done_nx_s;
         err     <= err_nx_s;
      end
   end

endmodule

// File: tb/tb_reg_bus_sched.sv
// Self-checking bench for reg_bus_sched: a transfer-schedule model predicts
// every strobe per cycle, plus directed literal checks and a latch-bank model.
module tb_reg_bus_sched;

   localparam int NREQ  = 4;
   localparam int NLAT  = 8;
   localparam int DEPTH = 32768;

   logic                 clk = 1'b0;
   logic                 nreset;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0][2:0] src;
   logic [NREQ-1:0][2:0] dst;
   logic                 ext_busy;
   logic [NLAT-1:0]      oe, we;
   logic [NREQ-1:0]      gnt, done;
   logic                 err;

   reg_bus_sched #(.NREQ(NREQ), .NLAT(NLAT)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .req      (req),
      .src      (src),
      .dst      (dst),
      .ext_busy (ext_busy),
      .oe       (oe),
      .we       (we),
      .gnt      (gnt),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int e        = 0;
   bit model_on = 1'b0;

   logic [NLAT-1:0] exp_oe   [DEPTH];
   logic [NLAT-1:0] exp_we   [DEPTH];
   logic [NREQ-1:0] exp_gnt  [DEPTH];
   logic [NREQ-1:0] exp_done [DEPTH];
   logic            exp_err  [DEPTH];
   logic [7:0]      lat      [NLAT];

   int              rr     = 0;
   int              turn_w = -10;
   int              last_w = 0;
   int              m_w;
   bit              m_found;
   logic [NREQ-1:0] m_elig;
   logic [2:0]      m_s, m_d;
   logic [7:0]      m_db;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nreset   = 1'b0;
      req      = '0;
      ext_busy = 1'b0;
      tick(1);
      nreset   = 1'b1;
   endtask

   // Schedule model: a transfer launched at edge e owns cycles e, e+1, e+2.
   always @(posedge clk) begin
      e = e + 1;
      m_db = 8'h00;
      for (int j = 0; j < NLAT; j++) if (oe[j]) m_db = m_db | lat[j];
      for (int j = 0; j < NLAT; j++) if (we[j]) lat[j] = m_db;
      if (!nreset) begin
         model_on = 1'b1;
         rr       = 0;
         turn_w   = -10;
         for (int k = 0; k < 4; k++) begin
            exp_oe[e+k] = '0; exp_we[e+k] = '0; exp_gnt[e+k] = '0;
            exp_done[e+k] = '0; exp_err[e+k] = 1'b0;
         end
      end else if (model_on && (e - 1 >= turn_w) && !ext_busy) begin
         m_elig = req;
         if (e - 1 == turn_w) m_elig[last_w] = 1'b0;
         m_found = 1'b0;
         m_w     = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!m_found && m_elig[(rr + k) % NREQ]) begin
               m_found = 1'b1;
               m_w     = (rr + k) % NREQ;
            end
         end
         if (m_found) begin
            m_s = src[m_w];
            m_d = dst[m_w];
            exp_oe[e]     = 8'd1 << m_s;
            exp_gnt[e]    = 4'd1 << m_w;
            exp_oe[e+1]   = 8'd1 << m_s;
            exp_we[e+1]   = (m_s != m_d) ? (8'd1 << m_d) : 8'd0;
            exp_done[e+2] = 4'd1 << m_w;
            exp_err[e+2]  = (m_s == m_d);
            turn_w        = e + 2;
            last_w        = m_w;
            rr            = (m_w + 1) % NREQ;
         end
      end
   end

   // Per-cycle comparison of every strobe against the model, plus bus-safety rules.
   always @(negedge clk) begin
      if (model_on && e < DEPTH) begin
         chk("oe",   32'(oe),   32'(exp_oe[e]));
         chk("we",   32'(we),   32'(exp_we[e]));
         chk("gnt",  32'(gnt),  32'(exp_gnt[e]));
         chk("done", 32'(done), 32'(exp_done[e]));
         chk("err",  32'(err),  32'(exp_err[e]));
         chk("oe_onehot",   32'($countones(oe) <= 1), 32'd1);
         chk("we_onehot",   32'($countones(we) <= 1), 32'd1);
         chk("we_without_oe", 32'((we != 8'd0) && (oe == 8'd0)), 32'd0);
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         exp_oe[i] = '0; exp_we[i] = '0; exp_gnt[i] = '0; exp_done[i] = '0; exp_err[i] = 1'b0;
      end
      for (int j = 0; j < NLAT; j++) lat[j] = 8'(8'h10 * j);
      lat[2]   = 8'h55;
      nreset   = 1'b0;
      req      = '0;
      src      = '0;
      dst      = '0;
      ext_busy = 1'b0;
      tick(2);
      chk("reset_oe",   32'(oe),   32'h0);
      chk("reset_we",   32'(we),   32'h0);
      chk("reset_gnt",  32'(gnt),  32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_err",  32'(err),  32'h0);

      // single transfer latch 2 -> latch 5
      nreset = 1'b1; req = 4'b0001; src[0] = 3'd2; dst[0] = 3'd5;
      tick(1);
      chk("t1_drive_oe", 32'(oe), 32'h04); chk("t1_drive_we", 32'(we), 32'h00); chk("t1_gnt", 32'(gnt), 32'h1);
      tick(1);
      chk("t1_write_oe", 32'(oe), 32'h04); chk("t1_write_we", 32'(we), 32'h20);
      tick(1);
      chk("t1_turn_oe", 32'(oe), 32'h00); chk("t1_done", 32'(done), 32'h1); chk("t1_err", 32'(err), 32'h0);
      req = 4'b0000;
      tick(1);
      chk("t1_latch5", 32'(lat[5]), 32'h55);

      // full contention: grants 0,1,2,3,0 three cycles apart
      do_reset();
      for (int i = 0; i < NREQ; i++) begin src[i] = 3'(i); dst[i] = 3'(7 - i); end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [3:0] g;
         g = 4'b0001 << (k % 4);
         tick(1);
         chk("rr_gnt", 32'(gnt), 32'(g));
         if (k < 4) tick(2);
      end
      req = 4'b0000;
      tick(3);

      // ext_busy blocks starts until it drops in cycle 10
      do_reset();
      ext_busy = 1'b1; req = 4'b0010; src[1] = 3'd1; dst[1] = 3'd6;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         chk("busy_gnt", 32'(gnt), 32'h0); chk("busy_oe", 32'(oe), 32'h0);
      end
      ext_busy = 1'b0;
      tick(1);
      chk("busy_release_gnt", 32'(gnt), 32'h2); chk("busy_release_oe", 32'(oe), 32'h02);
      tick(1);
      req = 4'b0000;
      tick(2);

      // src equals dst: no write, err with done
      do_reset();
      req = 4'b0100; src[2] = 3'd3; dst[2] = 3'd3;
      tick(1);
      chk("same_drive_oe", 32'(oe), 32'h08); chk("same_drive_we", 32'(we), 32'h00);
      tick(1);
      chk("same_write_oe", 32'(oe), 32'h08); chk("same_write_we", 32'(we), 32'h00);
      tick(1);
      chk("same_done", 32'(done), 32'h4); chk("same_err", 32'(err), 32'h1);
      req = 4'b0000;
      tick(1);

      // reset during WRITE aborts; next grant goes to requester 0
      do_reset();
      req = 4'b0010; src[1] = 3'd1; dst[1] = 3'd6;
      tick(2);
      chk("abort_write_we", 32'(we), 32'h40);
      nreset = 1'b0; req = 4'b1111;
      tick(1);
      chk("abort_oe", 32'(oe), 32'h0); chk("abort_we", 32'(we), 32'h0); chk("abort_done", 32'(done), 32'h0);
      nreset = 1'b1;
      tick(1);
      chk("abort_regrant", 32'(gnt), 32'h1); chk("abort_no_done", 32'(done), 32'h0);
      req = 4'b0000;
      tick(4);

      // random traffic with occasional resets and external bus ownership
      for (int c = 0; c < 10000; c++) begin
         req      = 4'($urandom);
         src      = 12'($urandom);
         dst      = 12'($urandom);
         ext_busy = ($urandom_range(0, 3) == 0);
         nreset   = ($urandom_range(0, 499) != 0);
         tick(1);
      end
      nreset = 1'b1; req = '0; ext_busy = 1'b0;
      tick(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_bus_sched.md
REG_BUS_SCHED -- requirements
Module: reg_bus_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the internal data bus.
REQ-002 Parameter NLAT, default 8: number of reg_latch instances on the bus.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 nreset  input  1  reset, synchronous, active-low.
REQ-005 req  input  NREQ  per-requester transfer request; held high until done.
REQ-006 src  input  NREQ x log2(NLAT)  per-requester source latch index.
REQ-007 dst  input  NREQ x log2(NLAT)  per-requester destination latch index.
REQ-008 ext_busy  input  1  external agent owns db; no new transfer may start.
REQ-009 oe  output  NLAT  one-hot/zero latch output enables, one per latch.
REQ-010 we  output  NLAT  one-hot/zero latch write enables, one per latch.
REQ-011 gnt  output  NREQ  one-cycle pulse marking start of a requester's transfer.
REQ-012 done  output  NREQ  one-cycle pulse marking completion of a requester's transfer.
REQ-013 err  output  1  one-cycle pulse, coincident with done, when src equals dst.

Function
REQ-014 FSM states: IDLE, DRIVE, WRITE, TURN; all outputs registered.
REQ-015 IDLE: if ext_busy low and any req high, latch winner index, its src and dst, and go to DRIVE; otherwise stay.
REQ-016 DRIVE (1 cycle): oe[src] high, we all low, gnt[winner] high.
REQ-017 WRITE (1 cycle): oe[src] high, we[dst] high; we is suppressed when src equals dst.
REQ-018 TURN (1 cycle): oe and we all low (bus turnaround), done[winner] high, err high if src equals dst.
REQ-019 TURN exit: go to DRIVE if ext_busy low and any req high (excluding the just-finished requester's same-cycle req), else IDLE.
REQ-020 Transfer latency: req sampled in cycle N gives DRIVE at N+1, WRITE at N+2, TURN/done at N+3.
REQ-021 Back-to-back throughput: one transfer per 3 cycles.
REQ-022 Arbitration: round-robin; after granting requester i, priority order starts at i+1 modulo NREQ.
REQ-023 src and dst are captured at grant; changes during the transfer are ignored.
REQ-024 req deasserted mid-transfer: transfer completes and done still pulses.
REQ-025 ext_busy rising mid-transfer: the transfer completes; only new starts are blocked.
REQ-026 At most one bit of oe and at most one bit of we is high in any cycle.
REQ-027 we is never high in a cycle where oe is all low.
REQ-028 Requester holding req after done is re-arbitrated normally with lowest priority.

Reset
REQ-029 nreset low at a clock edge: state IDLE, oe, we, gnt, done, err all 0, round-robin pointer 0 (requester 0 highest).
REQ-030 Reset mid-transfer aborts it: no done pulse, and all strobes are low on the next cycle.

Structure
REQ-031 Shared package reg_sched_pkg holds the state enum, default NREQ/NLAT constants and the latch-index width.
REQ-032 Sub-module rr_arbiter (req vector, pointer in, one-hot grant and index out, combinational) is instantiated once.

Verification
REQ-033 Single transfer: req[0]=1, src=2, dst=5 at cycle 0 -> oe=0x04 in cycles 1-2, we=0x20 in cycle 2, done[0] in cycle 3, latch 5 reads the value preloaded in latch 2 (0x55).
REQ-034 Contention: req=4'b1111 held after reset -> gnt order 0,1,2,3,0, with gnt pulses 3 cycles apart.
REQ-035 ext_busy=1 with req[1]=1 -> no gnt and oe/we=0; ext_busy drops at cycle 10 -> DRIVE at cycle 11.
REQ-036 src=dst=3 -> oe=0x08 for 2 cycles, we stays 0, done and err pulse together.
REQ-037 nreset low during WRITE -> next cycle oe=we=0, no done pulse, next grant goes to requester 0.
REQ-038 Random req/src/dst for 10k cycles -> one-hot assertions REQ-026/027 hold, and every gnt is followed by exactly one done 2 cycles later.
